// File: rtl/lsu_pkg.sv
// Shared encodings and the request legality check for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } lsu_state_e;

    // True for an illegal size, a lane offset that breaks natural alignment,
    // or a request that asks to read and write at once.
    function automatic logic bad_request(input logic [1:0] size,
                                         input logic [1:0] lane,
                                         input logic       rd,
                                         input logic       wr);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: extract+extend for loads, byte/half merge for stores.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = word[7:0];
        half_sel  = lane[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = wdata;
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
        endcase
        case (size)
            SZ_BYTE: begin
                load_data = {{24{byte_sel[7] & ~load_unsigned}}, byte_sel};
                merged    = word;
                case (lane)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data = {{16{half_sel[15] & ~load_unsigned}}, half_sel};
                merged    = word;
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory with
// combinational read; sub-word stores are done as a registered read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_AW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       size,
    input  logic             load_unsigned,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rvalid,
    output logic             err,
    output logic [DM_AW-1:0] dm_a,
    output logic [31:0]      dm_wd,
    output logic             dm_we,
    input  logic [31:0]      dm_rd
);

    // Valid/ready: a request transfers on a posedge where req_valid and
    // req_ready are both high; req_ready depends only on state and reset.

    lsu_state_e       state, state_nxt;
    logic [31:0]      merge_q;
    logic [DM_AW-1:0] idx_q;
    logic [DM_AW-1:0] idx;
    logic [31:0]      lane_load, lane_merged;
    logic             accept, bad, ld_ok, st_ok, st_word, st_sub;
    logic             unused_addr_hi;

    assign idx            = addr[DM_AW+1:2];
    assign unused_addr_hi = ^addr[31:DM_AW+2];

    assign req_ready = rst_n & (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign bad       = bad_request(size, addr[1:0], mem_read, mem_write);
    assign ld_ok     = accept & ~bad & mem_read;
    assign st_ok     = accept & ~bad & mem_write;
    assign st_word   = st_ok & (size == SZ_WORD);
    assign st_sub    = st_ok & (size != SZ_WORD);

    lsu_lane_unit u_lane (
        .word          (dm_rd),
        .size          (size),
        .lane          (addr[1:0]),
        .load_unsigned (load_unsigned),
        .wdata         (wdata),
        .load_data     (lane_load),
        .merged        (lane_merged)
    );

    always_comb begin
        state_nxt = state;
        dm_a      = idx;
        dm_wd     = '0;
        dm_we     = 1'b0;
        case (state)
            IDLE: begin
                if (st_word) begin
                    dm_we = 1'b1;
                    dm_wd = wdata;
                end
                if (st_sub) state_nxt = WRITE;
            end
            WRITE: begin
                // Gate with rst_n so a reset mid-RMW drops the write at once.
                dm_a      = idx_q;
                dm_wd     = merge_q;
                dm_we     = rst_n;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdata   <= '0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            merge_q <= '0;
            idx_q   <= '0;
        end else begin
            state  <= state_nxt;
            rvalid <= ld_ok;
            err    <= accept & bad;
            if (ld_ok) rdata <= lane_load;
            if (st_sub) begin
                merge_q <= lane_merged;
                idx_q   <= idx;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model, per-cycle compare, directed and random requests.
module tb_load_store_unit;

  localparam int DM_AW = 12;
  localparam int MAXC  = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic req_ready, rvalid, err, dm_we;
  logic [31:0] rdata, dm_wd, dm_rd;
  logic [DM_AW-1:0] dm_a;

  load_store_unit #(.DM_AW(DM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .err(err),
    .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // data memory the DUT drives
  logic [31:0] tb_mem [0:4095];
  assign dm_rd = tb_mem[dm_a];
  always @(posedge clk) if (dm_we) tb_mem[dm_a] <= dm_wd;

  // reference model state: byte-addressed memory and per-cycle expectations
  logic [7:0]  ref_b [0:16383];
  logic [31:0] exp_q[$];
  bit          exp_we [MAXC];
  bit          exp_rv [MAXC];
  bit          exp_err [MAXC];
  bit          exp_busy [MAXC];
  logic [11:0] exp_wa [MAXC];
  logic [31:0] exp_wd [MAXC];
  int cyc = 0;
  int n_checks = 0, n_errs = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Apply one accepted request to the byte memory; record what the DUT must show.
  task automatic model_apply(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] wd,
                             input int c);
    int n, ba, wa, t;
    logic [31:0] v;
    logic bad;
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (rd && wr);
    n = 1 << sz;
    ba = int'(a[13:0]);
    if (c + 2 >= MAXC) return;
    if (bad) begin
      exp_err[c+1] = 1'b1;
    end else if (rd) begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_b[ba+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
      exp_q.push_back(v);
      exp_rv[c+1] = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < n; i++) ref_b[ba+i] = 8'(wd >> (8*i));
      wa = ba / 4;
      v = {ref_b[wa*4+3], ref_b[wa*4+2], ref_b[wa*4+1], ref_b[wa*4]};
      t = (n == 4) ? c : c + 1;
      exp_we[t] = 1'b1;
      exp_wa[t] = 12'(wa);
      exp_wd[t] = v;
      if (n < 4) exp_busy[c+1] = 1'b1;
    end
  endtask

  // driver: present a request, hold until accepted, return just after the accept edge
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    int w;
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz;
    load_unsigned = uns; addr = a; wdata = wd;
    w = 0;
    while (!req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_checks++;
      n_errs++;
      $display("FAIL req_ready_timeout: got=0 expected=1 at t=%0t", $time);
      req_valid = 1'b0;
      return;
    end
    model_apply(rd, wr, sz, uns, a, wd, cyc);
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // scoreboard: compare every cycle against the model
  always @(negedge clk) begin
    #2;
    if (chk_en && rst_n && cyc < MAXC) begin
      check("req_ready", 32'(req_ready), 32'(!exp_busy[cyc]));
      check("dm_we", 32'(dm_we), 32'(exp_we[cyc]));
      check("dm_wd", dm_wd, exp_we[cyc] ? exp_wd[cyc] : 32'd0);
      if (exp_we[cyc]) check("dm_a", 32'(dm_a), 32'(exp_wa[cyc]));
      check("rvalid", 32'(rvalid), 32'(exp_rv[cyc]));
      check("err", 32'(err), 32'(exp_err[cyc]));
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL rdata_unexpected: got=%h expected=none at t=%0t", rdata, $time);
        end else begin
          check("rdata", rdata, exp_q.pop_front());
        end
      end
    end
  end

  logic [31:0] old8;
  int mism;

  initial begin
    for (int w = 0; w < 4096; w++) begin
      logic [31:0] r;
      r = $urandom;
      tb_mem[w] = r;
      for (int b = 0; b < 4; b++) ref_b[w*4+b] = 8'(r >> (8*b));
    end

    // reset with a store request pending
    rst_n = 1'b0; req_valid = 1'b1; mem_write = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h1234;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    req_valid = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);
    chk_en = 1'b1;

    // sw then lw
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_lit", rdata, 32'hDEADBEEF);
    check("lw_rvalid_lit", 32'(rvalid), 32'd1);
    check("sw_mem_lit", tb_mem[4], 32'hDEADBEEF);

    // sb read-modify-write, then signed and unsigned byte loads
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h55);
    check("sb_busy_lit", 32'(req_ready), 32'd0);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb_lit", rdata, 32'hFFFFFFDE);
    check("sb_mem_lit", tb_mem[4], 32'hDE55BEEF);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lbu_lit", rdata, 32'h000000DE);

    // sh then lh/lhu
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h8001);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lh_lit", rdata, 32'hFFFF8001);
    check("sh_mem_lit", tb_mem[4], 32'h8001BEEF);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lhu_lit", rdata, 32'h00008001);

    // misaligned and illegal requests
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    check("err_lw_mis", 32'({err, rvalid}), 32'b10);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF);
    check("err_sh_mis", 32'({err, rvalid}), 32'b10);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check("err_size11", 32'({err, rvalid}), 32'b10);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADF00D);
    check("err_rdwr", 32'({err, rvalid}), 32'b10);
    @(negedge clk);
    check("err_mem_lit", tb_mem[4], 32'h8001BEEF);

    // reset during the write cycle of a sub-word store
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    @(negedge clk);
    old8 = tb_mem[8];
    check("pre_rmw_mem_lit", old8, 32'h11223344);
    chk_en = 1'b0;
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'hA5;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_write = 1'b0;
    check("rmw_we_write", 32'(dm_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw_rst_we", 32'(dm_we), 32'd0);
    check("rmw_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmw_rel_ready", 32'(req_ready), 32'd1);
    check("rmw_mem8", tb_mem[8], old8);
    chk_en = 1'b1;

    // randomized requests with aliasing addresses and index wrap
    for (int k = 0; k < 300; k++) begin
      int op, sr, g;
      logic rd, wr, uns;
      logic [1:0] sz, off;
      logic [11:0] idx;
      logic [31:0] a, hi;
      op = $urandom_range(0, 19);
      rd = (op < 9) || (op == 18);
      wr = (op >= 9 && op < 19);
      sr = $urandom_range(0, 9);
      sz = (sr < 3) ? 2'b00 : (sr < 6) ? 2'b01 : (sr < 9) ? 2'b10 : 2'b11;
      uns = 1'($urandom);
      off = 2'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) off[0] = 1'b0;
        if (sz == 2'b10) off = 2'b00;
      end
      idx = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      hi = $urandom;
      a = {hi[17:0], idx, off};
      issue(rd, wr, sz, uns, a, $urandom);
      g = $urandom_range(0, 2);
      repeat (g) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    mism = 0;
    for (int w = 0; w < 4096; w++)
      if (tb_mem[w] !== {ref_b[w*4+3], ref_b[w*4+2], ref_b[w*4+1], ref_b[w*4]}) mism++;
    check("mem_final_mismatches", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
